// File: rtl/dds_pkg.sv
// Shared types, waveform codes and saturating arithmetic for the DDS sweep controller.
package dds_pkg;

  localparam int FREQ_W_DEF = 25;
  localparam int SAT_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DWELL,
    ST_NEXT,
    ST_DONE
  } sweep_state_t;

  localparam logic [3:0] WAVE_SIN = 4'b0001;
  localparam logic [3:0] WAVE_SQU = 4'b0010;
  localparam logic [3:0] WAVE_TRI = 4'b0100;
  localparam logic [3:0] WAVE_SAW = 4'b1000;

  // Adds one bit wider than the operands, then clamps to the signed range of a w-bit word (w < SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    one = {{SAT_W{1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi)      return hi[SAT_W-1:0];
    else if (sum < lo) return lo[SAT_W-1:0];
    else               return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration, control and DDS-facing signals of the sweep controller.
interface dds_sweep_ctrl_if #(
  parameter int FREQ_W = 25,
  parameter int CNT_W  = 24,
  parameter int IDX_W  = 16
);
  logic                     start;
  logic                     abort;
  logic signed [FREQ_W-1:0] cfg_start_freq;
  logic signed [FREQ_W-1:0] cfg_step;
  logic [IDX_W-1:0]         cfg_num_steps;
  logic [CNT_W-1:0]         cfg_settle;
  logic [CNT_W-1:0]         cfg_dwell;
  logic [3:0]               cfg_wave;

  logic signed [FREQ_W-1:0] freq_mod_o;
  logic [3:0]               wave_select_o;
  logic                     busy;
  logic                     settled;
  logic                     step_strobe;
  logic [IDX_W-1:0]         step_idx;
  logic                     done;

  modport master (
    output start, abort, cfg_start_freq, cfg_step, cfg_num_steps,
           cfg_settle, cfg_dwell, cfg_wave,
    input  freq_mod_o, wave_select_o, busy, settled, step_strobe, step_idx, done
  );

  modport slave (
    input  start, abort, cfg_start_freq, cfg_step, cfg_num_steps,
           cfg_settle, cfg_dwell, cfg_wave,
    output freq_mod_o, wave_select_o, busy, settled, step_strobe, step_idx, done
  );
endinterface

// File: rtl/dds_dwell_timer.sv
// Load / count-down / expire timer shared by the settle and dwell phases.
module dds_dwell_timer #(
  parameter int CNT_W = 24
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  // A load of v keeps the timer running for v+1 cycles before expiry.
  assign expired = (count == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Steps the DDS frequency-mod word through a programmed sweep with settle/dwell timing.
// Optional macro DDS_SWEEP_BIDIR_EN adds a return sweep back down to the start frequency.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int CNT_W  = 24,
  parameter int IDX_W  = 16
) (
  input logic             sys_clk,
  input logic             rst,
  dds_sweep_ctrl_if.slave bus
);

  sweep_state_t             state;
  logic signed [FREQ_W-1:0] sh_start_freq;
  logic signed [FREQ_W-1:0] sh_step;
  logic [IDX_W-1:0]         sh_last_idx;
  logic [CNT_W-1:0]         sh_settle;
  logic [CNT_W-1:0]         sh_dwell_m1;
  logic [3:0]               sh_wave;

  logic                     tmr_load;
  logic [CNT_W-1:0]         tmr_val;
  logic                     tmr_expired;

  logic                     sweep_last;
  logic                     step_down;
  logic signed [SAT_W-1:0]  cur_ext;
  logic signed [SAT_W-1:0]  inc_ext;
  logic signed [SAT_W-1:0]  sum_ext;
  logic signed [FREQ_W-1:0] next_freq;

`ifdef DDS_SWEEP_BIDIR_EN
  logic dir_down;
`endif

  dds_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_NEXT: begin
        tmr_load = 1'b1;
        tmr_val  = (sh_settle != '0) ? sh_settle - 1'b1 : sh_dwell_m1;
      end
      ST_SETTLE: begin
        tmr_load = tmr_expired;
        tmr_val  = sh_dwell_m1;
      end
      default: ;
    endcase
  end

  always_comb begin
`ifdef DDS_SWEEP_BIDIR_EN
    if (!dir_down) begin
      sweep_last = (bus.step_idx == sh_last_idx) && (sh_last_idx == '0);
      step_down  = (bus.step_idx == sh_last_idx);
    end else begin
      sweep_last = (bus.step_idx == '0);
      step_down  = 1'b1;
    end
`else
    sweep_last = (bus.step_idx == sh_last_idx);
    step_down  = 1'b0;
`endif
  end

  assign cur_ext   = {{(SAT_W-FREQ_W){bus.freq_mod_o[FREQ_W-1]}}, bus.freq_mod_o};
  assign inc_ext   = step_down ? -{{(SAT_W-FREQ_W){sh_step[FREQ_W-1]}}, sh_step}
                               :  {{(SAT_W-FREQ_W){sh_step[FREQ_W-1]}}, sh_step};
  assign sum_ext   = sat_add(cur_ext, inc_ext, FREQ_W);
  assign next_freq = sum_ext[FREQ_W-1:0];

  // LOAD is a one-cycle pipeline stage; NEXT is the cycle in which a new frequency is strobed.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      sh_start_freq     <= '0;
      sh_step           <= '0;
      sh_last_idx       <= '0;
      sh_settle         <= '0;
      sh_dwell_m1       <= '0;
      sh_wave           <= WAVE_SIN;
      bus.freq_mod_o    <= '0;
      bus.wave_select_o <= WAVE_SIN;
      bus.busy          <= 1'b0;
      bus.settled       <= 1'b0;
      bus.step_strobe   <= 1'b0;
      bus.step_idx      <= '0;
      bus.done          <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      dir_down          <= 1'b0;
`endif
    end else begin
      bus.step_strobe <= 1'b0;
      bus.done        <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state          <= ST_IDLE;
        bus.freq_mod_o <= '0;
        bus.settled    <= 1'b0;
        bus.busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start && !bus.abort) begin
              sh_start_freq <= bus.cfg_start_freq;
              sh_step       <= bus.cfg_step;
              sh_last_idx   <= (bus.cfg_num_steps == '0) ? '0 : bus.cfg_num_steps - 1'b1;
              sh_settle     <= bus.cfg_settle;
              sh_dwell_m1   <= (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - 1'b1;
              sh_wave       <= bus.cfg_wave;
              state         <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            bus.freq_mod_o    <= sh_start_freq;
            bus.wave_select_o <= sh_wave;
            bus.step_idx      <= '0;
            bus.step_strobe   <= 1'b1;
            bus.busy          <= 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
            dir_down          <= 1'b0;
`endif
            state             <= ST_NEXT;
          end
          ST_NEXT: begin
            if (sh_settle != '0) begin
              state <= ST_SETTLE;
            end else begin
              state       <= ST_DWELL;
              bus.settled <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (tmr_expired) begin
              state       <= ST_DWELL;
              bus.settled <= 1'b1;
            end
          end
          ST_DWELL: begin
            if (tmr_expired) begin
              bus.settled <= 1'b0;
              if (sweep_last) begin
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                state    <= ST_DONE;
              end else begin
                bus.freq_mod_o  <= next_freq;
                bus.step_idx    <= step_down ? bus.step_idx - 1'b1 : bus.step_idx + 1'b1;
                bus.step_strobe <= 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
                dir_down        <= step_down;
`endif
                state           <= ST_NEXT;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl; outputs are sampled on the falling edge.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int FREQ_W = 25;
  localparam int CNT_W  = 24;
  localparam int IDX_W  = 16;
  localparam int CAP_N  = 72;
`ifdef DDS_SWEEP_BIDIR_EN
  localparam int BIDIR = 1;
`else
  localparam int BIDIR = 0;
`endif

  logic sys_clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic signed [FREQ_W-1:0] cap_freq   [CAP_N];
  logic [3:0]               cap_wave   [CAP_N];
  logic                     cap_strobe [CAP_N];
  logic                     cap_settled[CAP_N];
  logic                     cap_busy   [CAP_N];
  logic                     cap_done   [CAP_N];
  logic [IDX_W-1:0]         cap_idx    [CAP_N];

  dds_sweep_ctrl_if #(.FREQ_W(FREQ_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  dds_sweep_ctrl #(.FREQ_W(FREQ_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic signed [FREQ_W-1:0] f0, input logic signed [FREQ_W-1:0] stp,
                         input int n, input int settle, input int dwell, input logic [3:0] wave);
    bus.cfg_start_freq = f0;
    bus.cfg_step       = stp;
    bus.cfg_num_steps  = IDX_W'(n);
    bus.cfg_settle     = CNT_W'(settle);
    bus.cfg_dwell      = CNT_W'(dwell);
    bus.cfg_wave       = wave;
  endtask

  // Returns in the cycle right after the edge that sampled start; capture index 0 is the next cycle.
  task automatic do_start();
    @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      cap_freq[i]    = bus.freq_mod_o;
      cap_wave[i]    = bus.wave_select_o;
      cap_strobe[i]  = bus.step_strobe;
      cap_settled[i] = bus.settled;
      cap_busy[i]    = bus.busy;
      cap_done[i]    = bus.done;
      cap_idx[i]     = bus.step_idx;
    end
  endtask

  function automatic int first_done(input int n);
    for (int i = 0; i < n; i++) if (cap_done[i]) return i;
    return -1;
  endfunction

  initial begin
    int pts;
    int n_strobe;
    int n_settled;
    int n_done;
    int n_busy;
    int d_idx;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, WAVE_SIN);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    check("rst_freq",    bus.freq_mod_o,    0);
    check("rst_wave",    bus.wave_select_o, WAVE_SIN);
    check("rst_busy",    bus.busy,          0);
    check("rst_settled", bus.settled,       0);
    check("rst_strobe",  bus.step_strobe,   0);
    check("rst_idx",     bus.step_idx,      0);
    check("rst_done",    bus.done,          0);

    // Basic sweep; cfg is scrambled right after start to show the shadow registers hold.
    set_cfg(0, 320, 4, 3, 5, WAVE_TRI);
    do_start();
    set_cfg(0, 999, 1, 0, 0, WAVE_SAW);
    capture(CAP_N);
    pts = BIDIR ? 7 : 4;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("basic_freq_first%0d", k), cap_freq[9*k],     320 * k);
      check($sformatf("basic_freq_last%0d", k),  cap_freq[9*k+8],   320 * k);
      check($sformatf("basic_strobe%0d", k),     cap_strobe[9*k],   1);
      check($sformatf("basic_idx%0d", k),        cap_idx[9*k],      k);
      check($sformatf("basic_settle_end%0d", k), cap_settled[9*k+3], 0);
      check($sformatf("basic_dwell_beg%0d", k),  cap_settled[9*k+4], 1);
    end
    check("basic_busy0", cap_busy[0], 1);
    check("basic_wave0", cap_wave[0], WAVE_TRI);
    n_strobe  = 0;
    n_settled = 0;
    n_done    = 0;
    for (int i = 0; i < CAP_N; i++) begin
      n_strobe  += int'(cap_strobe[i]);
      n_settled += int'(cap_settled[i]);
      n_done    += int'(cap_done[i]);
    end
    check("basic_n_strobe",  n_strobe,  pts);
    check("basic_n_settled", n_settled, 5 * pts);
    check("basic_n_done",    n_done,    1);
    d_idx = first_done(CAP_N);
    check("basic_done_idx",  d_idx,     9 * pts);
    if (d_idx > 0) begin
      check("basic_busy_pre_done", cap_busy[d_idx-1], 1);
      check("basic_busy_at_done",  cap_busy[d_idx],   0);
      check("basic_freq_hold",     cap_freq[d_idx],   BIDIR ? 0 : 960);
      check("basic_wave_hold",     cap_wave[d_idx],   WAVE_TRI);
    end

    // Positive saturation.
    set_cfg(25'sd16777000, 25'sd200, 3, 0, 1, WAVE_SIN);
    do_start();
    capture(CAP_N);
    check("sat_f0", cap_freq[0], 16777000);
    check("sat_f1", cap_freq[2], 16777200);
    check("sat_f2", cap_freq[4], 16777215);
    check("sat_done_idx", first_done(CAP_N), BIDIR ? 10 : 6);

    // Abort during step 2 dwell.
    set_cfg(0, 320, 4, 3, 5, WAVE_SQU);
    do_start();
    repeat (24) @(negedge sys_clk);
    check("abort_pre_settled", bus.settled,  1);
    check("abort_pre_idx",     bus.step_idx, 2);
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort = 1'b0;
    check("abort_freq",    bus.freq_mod_o, 0);
    check("abort_busy",    bus.busy,       0);
    check("abort_settled", bus.settled,    0);
    capture(40);
    n_done   = 0;
    n_strobe = 0;
    for (int i = 0; i < 40; i++) begin
      n_done   += int'(cap_done[i]);
      n_strobe += int'(cap_strobe[i]);
    end
    check("abort_no_done",   n_done,   0);
    check("abort_no_strobe", n_strobe, 0);

    // Abort and start together in IDLE: start is dropped.
    @(negedge sys_clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    capture(20);
    n_busy   = 0;
    n_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      n_busy   += int'(cap_busy[i]);
      n_strobe += int'(cap_strobe[i]);
    end
    check("abort_start_busy",   n_busy,   0);
    check("abort_start_strobe", n_strobe, 0);

    // Degenerate config, then an immediate restart in the cycle after done.
    set_cfg(-25'sd500, 25'sd7, 0, 0, 0, WAVE_SIN);
    do_start();
    capture(3);
    check("degen_strobe",  cap_strobe[0],  1);
    check("degen_freq",    cap_freq[0],    -500);
    check("degen_settle0", cap_settled[0], 0);
    check("degen_settle1", cap_settled[1], 1);
    check("degen_settle2", cap_settled[2], 0);
    check("degen_done",    cap_done[2],    1);
    check("degen_busy",    cap_busy[2],    0);
    do_start();
    capture(1);
    check("restart_strobe", cap_strobe[0], 1);
    check("restart_busy",   cap_busy[0],   1);
    capture(4);

    // Up sweep (and return, when enabled).
    set_cfg(0, 100, 3, 0, 1, WAVE_SIN);
    do_start();
    capture(CAP_N);
    check("dir_f0", cap_freq[0], 0);
    check("dir_f1", cap_freq[2], 100);
    check("dir_f2", cap_freq[4], 200);
`ifdef DDS_SWEEP_BIDIR_EN
    check("dir_f3",   cap_freq[6], 100);
    check("dir_f4",   cap_freq[8], 0);
    check("dir_idx3", cap_idx[6],  1);
    check("dir_idx4", cap_idx[8],  0);
    check("dir_done_idx", first_done(CAP_N), 10);
`else
    check("dir_done_idx", first_done(CAP_N), 6);
`endif

    // Reset mid-sweep returns every output to its reset value at once.
    set_cfg(0, 320, 4, 3, 5, WAVE_TRI);
    do_start();
    repeat (11) @(negedge sys_clk);
    check("mid_pre_freq", bus.freq_mod_o, 320);
    rst = 1'b1;
    #1;
    check("mid_rst_freq",    bus.freq_mod_o,    0);
    check("mid_rst_wave",    bus.wave_select_o, WAVE_SIN);
    check("mid_rst_busy",    bus.busy,          0);
    check("mid_rst_settled", bus.settled,       0);
    check("mid_rst_idx",     bus.step_idx,      0);
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer that drives the DDS reference generator through a programmed frequency sweep for lock-in frequency-response measurements. It steps the signed frequency-modulation word `freq_mod_o`, which feeds the DDS `freq_mod_i`, and drives the waveform select. At each step it holds a settle interval and then a dwell interval. During the dwell it raises `settled` so the downstream demodulator/accumulator integrates only on a stable reference.

## Interface
- `FREQ_W`, 25: width of the signed frequency-mod word. Matches the DDS `freq_mod_i`.
- `CNT_W`, 24: width of the settle and dwell counters.
- `IDX_W`, 16: width of the step count and step index.
- `sys_clk` in 1: single clock, shared with the DDS.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a sweep.
- `abort` in 1: terminate the sweep immediately.
- `cfg_start_freq` in FREQ_W (signed): frequency-mod word for step 0.
- `cfg_step` in FREQ_W (signed): increment per step.
- `cfg_num_steps` in IDX_W: number of frequency points.
- `cfg_settle` in CNT_W: cycles per step with `settled`=0.
- `cfg_dwell` in CNT_W: cycles per step with `settled`=1.
- `cfg_wave` in 4: one-hot waveform code.
- `freq_mod_o` out FREQ_W (signed): goes to the DDS `freq_mod_i`.
- `wave_select_o` out 4: goes to the DDS `wave_select`.
- `busy` out 1: sweep in progress.
- `settled` out 1: demodulator integrate-enable.
- `step_strobe` out 1: one-cycle pulse when a new step's frequency is applied.
- `step_idx` out IDX_W: index of the current step.
- `done` out 1: one-cycle pulse when a sweep completes normally.

## Operation
- **States:** IDLE, LOAD, SETTLE, DWELL, NEXT, DONE.
- **IDLE:**
  - `start` latches all `cfg_*` inputs into shadow registers, then go to LOAD.
  - `cfg_*` changes during a sweep have no effect.
- **LOAD:**
  - `freq_mod_o` <= start_freq, `wave_select_o` <= wave, `step_idx` <= 0, pulse `step_strobe`.
  - Go to SETTLE, or to DWELL if settle == 0.
  - `wave_select_o` changes only here, because a wave change clears the DDS phase accumulator.
- **SETTLE:** count settle cycles, then go to DWELL.
- **DWELL:**
  - `settled` = 1; count dwell cycles (dwell == 0 is treated as 1).
  - At expiry: if `step_idx` == num_steps−1, go to DONE; otherwise go to NEXT.
  - num_steps == 0 is treated as 1.
- **NEXT:**
  - `freq_mod_o` <= sat(`freq_mod_o` + step), `step_idx`++, pulse `step_strobe`.
  - Go to SETTLE (or DWELL if settle == 0).
- **DONE:** pulse `done`, go to IDLE. `freq_mod_o` and `wave_select_o` hold their last values.
- **Arithmetic:**
  - The add is done at FREQ_W+1 bits and saturated to [−2^(FREQ_W−1), 2^(FREQ_W−1)−1].
  - Once saturated, `freq_mod_o` stays pinned for the remaining steps. The sweep is not terminated early.
  - The DDS uses only bits [23:5] of the word, so steps smaller than 32 LSB do not change the output frequency.
- **Abort:**
  - In any non-IDLE state, go to IDLE on the next edge.
  - `freq_mod_o` <= 0, `settled` = 0, no `done` pulse.
  - Abort in IDLE has no effect. If `abort` and `start` are high in the same cycle, abort wins and start is dropped.
- **`start` while busy:** ignored.

## Timing
- **Reset values:** `freq_mod_o`=0, `wave_select_o`=4'b0001 (sine), `busy`=0, `settled`=0, `step_strobe`=0, `step_idx`=0, `done`=0, state IDLE.
- **All outputs are registered.**
- **Sweep start:**
  - `start` is sampled at edge N.
  - At edge N+1, `busy`=1 and the step-0 frequency, `step_strobe` and `wave_select_o` are visible.
- **Per step:**
  - Frequency is held exactly 1 + settle + dwell cycles; the extra cycle is LOAD or NEXT.
  - `settled` is high for exactly dwell cycles and falls in the cycle `step_strobe` rises.
- **Sweep end:**
  - `done` is high one cycle after the final dwell cycle.
  - `busy` falls in the same cycle as `done`.
- **Restart:** a new `start` is accepted in the cycle after `done`.
- **Reset mid-sweep:** immediate return to the reset values.

## Configuration
- **Macro `DDS_SWEEP_BIDIR_EN`:**
  - Defined: after the last up-step, the sweep reverses and steps by −step back to start_freq. `step_idx` counts down. Total points = 2·num_steps−1. `done` fires after the return-point dwell.
  - Undefined: single up-sweep only, with no direction register.

## Structure
- **Package `dds_pkg`:**
  - state enum.
  - wave one-hot constants: SIN=0001, SQU=0010, TRI=0100, SAW=1000.
  - `FREQ_W` default.
  - the saturating-add function.
- **Sub-module `dds_dwell_timer`:** load/count-down/expire counter of width CNT_W, used for both settle and dwell.

## Test plan
- **Basic sweep:** start_freq=0, step=320, num_steps=4, settle=3, dwell=5 -> `freq_mod_o` 0,320,640,960, each held 9 cycles. Four `step_strobe` pulses; `settled` high 5 cycles per step; `done` one cycle after the last dwell.
- **Saturation:** start_freq=16777000, step=+200, num_steps=3 -> outputs 16777000, 16777200, 16777215 (clamped).
- **Abort:** abort during step 2 DWELL -> next cycle IDLE, `freq_mod_o`=0, `busy`=0, no `done`. Abort and start high in the same cycle while in IDLE -> sweep does not start.
- **Degenerate config:** num_steps=0, settle=0, dwell=0 -> single point, `settled` high 1 cycle, `done` 3 cycles after `start`.
- **Config isolation:** change `cfg_step` and `cfg_wave` mid-sweep -> outputs unchanged. With `DDS_SWEEP_BIDIR_EN`, num_steps=3, step=100 -> 0,100,200,100,0 then `done`.
